reg_file_wb: RTL

- Register file and write-back stage for the 16-bit single-cycle core.
- Holds eight 16-bit general registers; R0 reads as zero and ignores writes.
- Drives both source operands to the ALU and branch comparator.
- Consumes reg_dest, mem_to_reg and reg_wr from the control unit to pick the write address and write data, and commits on the clock edge.

---
 rtl/core_pkg.sv | 22 ++
 rtl/wb_mux.sv | 43 ++++
 rtl/reg_file_wb.sv | 79 +++++++
 3 files changed

// File: rtl/core_pkg.sv
// Constants shared by the control unit and the register file / write-back.
// Select encodings, instruction field positions and datapath sizes.
package core_pkg;

   localparam int DATA_W   = 16;
   localparam int NREG     = 8;
   localparam int AW       = $clog2(NREG);
   localparam int LINK_REG = 7;

   localparam logic [1:0] REG_DEST_RT   = 2'b00;
   localparam logic [1:0] REG_DEST_RD   = 2'b01;
   localparam logic [1:0] REG_DEST_LINK = 2'b10;

   localparam logic [1:0] WB_SEL_ALU = 2'b00;
   localparam logic [1:0] WB_SEL_MEM = 2'b01;
   localparam logic [1:0] WB_SEL_PC2 = 2'b10;

   localparam int RS_LSB = 10;
   localparam int RT_LSB = 7;
   localparam int RD_LSB = 4;

endpackage

// File: rtl/wb_mux.sv
// Write-back selection: picks destination register and write data.
// Reserved select code 11 falls back to rt / alu_result.
module wb_mux
   import core_pkg::*;
#(
   parameter int DW   = DATA_W,
   parameter int AWD  = AW,
   parameter int LINK = LINK_REG
) (
   input  logic [AWD-1:0] rt,
   input  logic [AWD-1:0] rd,
   input  logic [1:0]     reg_dest,
   input  logic [1:0]     mem_to_reg,
   input  logic [DW-1:0]  alu_result,
   input  logic [DW-1:0]  mem_rdata,
   input  logic [DW-1:0]  pc_plus2,
   output logic [AWD-1:0] waddr,
   output logic [DW-1:0]  wdata
);

   localparam logic [AWD-1:0] LINK_A = AWD'(LINK);

   // Destination register select
   always_comb begin
      waddr = rt;
      case (reg_dest)
         REG_DEST_RD:   waddr = rd;
         REG_DEST_LINK: waddr = LINK_A;
         default:       waddr = rt;
      endcase
   end

   // Write data select
   always_comb begin
      wdata = alu_result;
      case (mem_to_reg)
         WB_SEL_MEM: wdata = mem_rdata;
         WB_SEL_PC2: wdata = pc_plus2;
         default:    wdata = alu_result;
      endcase
   end

endmodule

// File: rtl/reg_file_wb.sv
// Eight-entry register file with write-back commit and write counter.
// R0 is hardwired to zero; reads see the pre-edge value (no bypass).
module reg_file_wb
   import core_pkg::*;
#(
   parameter int DATA_W   = core_pkg::DATA_W,
   parameter int NREG     = core_pkg::NREG,
   parameter int LINK_REG = core_pkg::LINK_REG
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [15:0]       instr,
   input  logic [1:0]        reg_dest,
   input  logic [1:0]        mem_to_reg,
   input  logic              reg_wr,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic [DATA_W-1:0] pc_plus2,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   input  logic [2:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [15:0]       wr_count
);

   localparam int A = $clog2(NREG);

   logic [DATA_W-1:0] regs [NREG];
   logic [A-1:0]      rs;
   logic [A-1:0]      rt;
   logic [A-1:0]      rd;
   logic [A-1:0]      waddr;
   logic [DATA_W-1:0] wdata;
   logic              we;
   logic              unused_bits;

   assign rs = instr[RS_LSB +: A];
   assign rt = instr[RT_LSB +: A];
   assign rd = instr[RD_LSB +: A];
   assign unused_bits = ^{instr[15:13], instr[3:0]};

   wb_mux #(
      .DW   (DATA_W),
      .AWD  (A),
      .LINK (LINK_REG)
   ) u_wb_mux (
      .rt         (rt),
      .rd         (rd),
      .reg_dest   (reg_dest),
      .mem_to_reg (mem_to_reg),
      .alu_result (alu_result),
      .mem_rdata  (mem_rdata),
      .pc_plus2   (pc_plus2),
      .waddr      (waddr),
      .wdata      (wdata)
   );

   assign we = reg_wr && (waddr != '0);

   // Register array commit; R0 is never written
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   // Committed-write counter, wraps freely
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wr_count <= '0;
      else if (we) wr_count <= wr_count + 16'd1;
   end

   assign rs_data  = (rs == '0) ? '0 : regs[rs];
   assign rt_data  = (rt == '0) ? '0 : regs[rt];
   assign dbg_data = (dbg_addr[A-1:0] == '0) ? '0 : regs[dbg_addr[A-1:0]];

endmodule
